// File: rtl/sc_shiftcmd_pkg.sv
// ----------------------------------------------------------------------------
// sc_shiftcmd_pkg
// Shared definitions for the shift-command controller: FSM state encoding,
// shift-select codes driven towards the one-hot shift register, and small
// decode helpers used to build the registered outputs.
// ----------------------------------------------------------------------------
package sc_shiftcmd_pkg;

   // FSM state encoding (3-bit, kept as plain constants for legacy tools)
   localparam logic [2:0] ST_INIT    = 3'd0;
   localparam logic [2:0] ST_IDLE    = 3'd1;
   localparam logic [2:0] ST_SHIFT_L = 3'd2;
   localparam logic [2:0] ST_SHIFT_R = 3'd3;
   localparam logic [2:0] ST_HOLD_L  = 3'd4;
   localparam logic [2:0] ST_HOLD_R  = 3'd5;

   // Shift-select codes understood by the downstream shifter
   localparam logic [1:0] SHIFT_HOLD  = 2'b00;
   localparam logic [1:0] SHIFT_LEFT  = 2'b01;
   localparam logic [1:0] SHIFT_RIGHT = 2'b10;

   // Shift code issued while the FSM sits in a given state
   function automatic logic [1:0] shift_code_of(input logic [2:0] st);
      logic [1:0] code;
      case (st)
         ST_SHIFT_L: code = SHIFT_LEFT;
         ST_SHIFT_R: code = SHIFT_RIGHT;
         default:    code = SHIFT_HOLD;
      endcase
      return code;
   endfunction

   // A button is being held in either hold state
   function automatic logic is_hold_state(input logic [2:0] st);
      logic hold;
      case (st)
         ST_HOLD_L: hold = 1'b1;
         ST_HOLD_R: hold = 1'b1;
         default:   hold = 1'b0;
      endcase
      return hold;
   endfunction

endpackage

// File: rtl/sc_btn_sync_edge.sv
// ----------------------------------------------------------------------------
// sc_btn_sync_edge
// Conditions one raw active-low push-button: 2-flop synchronizer, a
// previous-value flop, and registered pressed level / press-edge outputs.
// Ports:
//   clk_i           system clock
//   rst_i           asynchronous active-high reset
//   btn_n_i         raw button, active-low, asynchronous to clk_i
//   pressed_level_o high while the synchronized button is pressed
//   press_pulse_o   one-cycle pulse on a synchronized high-to-low transition
// ----------------------------------------------------------------------------
module sc_btn_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_n_i,
   output logic pressed_level_o,
   output logic press_pulse_o
);

   logic       sync1_q;
   logic       sync2_q;
   logic       prev_q;
   logic [2:0] prime_q;
   logic       pressed_q;
   logic       press_q;

   // Synchronizer, edge history and registered level/edge outputs.
   // The chain resets to "released", so the first real sample of a button
   // that is already held would look like a press. prime_q only lets edges
   // through once both sync2_q and prev_q hold post-reset samples, so a
   // button held across reset needs a genuine release and re-press.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         prev_q    <= 1'b1;
         prime_q   <= 3'b000;
         pressed_q <= 1'b0;
         press_q   <= 1'b0;
      end else begin
         sync1_q   <= btn_n_i;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         prime_q   <= {prime_q[1:0], 1'b1};
         pressed_q <= ~sync2_q;
         press_q   <= prime_q[2] & prev_q & ~sync2_q;
      end
   end

   assign pressed_level_o = pressed_q;
   assign press_pulse_o   = press_q;

endmodule

// File: rtl/sc_shiftcmd_controller.sv
// ----------------------------------------------------------------------------
// sc_shiftcmd_controller
// Turns two raw active-low buttons into load / shift-select commands for the
// bounded one-hot shift register, with press-edge detection and auto-repeat.
// Ports:
//   SC_RegSHIFTER_P1_CLOCK_50     system clock, rising edge
//   SC_RegSHIFTER_P1_RESET_InHigh asynchronous active-high reset
//   btnLeft_InLow / btnRight_InLow raw buttons, active-low
//   load_OutLow                   low for exactly one cycle after reset
//   shiftselection_Out            01 left, 10 right, 00 hold (one-cycle pulses)
//   data_OutBUS                   constant load pattern INIT_VALUE
//   busy_Out                      high while a button is being held
// ----------------------------------------------------------------------------
module sc_shiftcmd_controller
   import sc_shiftcmd_pkg::*;
#(
   parameter int unsigned          DATAWIDTH    = 8,
   parameter logic [DATAWIDTH-1:0] INIT_VALUE   = 8'b00000001,
   parameter int unsigned          REPEAT_TICKS = 25000000,
   parameter int unsigned          CNT_WIDTH    = 25
)(
   input  logic                 SC_RegSHIFTER_P1_CLOCK_50,
   input  logic                 SC_RegSHIFTER_P1_RESET_InHigh,
   input  logic                 btnLeft_InLow,
   input  logic                 btnRight_InLow,
   output logic                 load_OutLow,
   output logic [1:0]           shiftselection_Out,
   output logic [DATAWIDTH-1:0] data_OutBUS,
   output logic                 busy_Out
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(REPEAT_TICKS - 32'd1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(32'd0);

   logic                 pressed_l_s, press_l_s;
   logic                 pressed_r_s, press_r_s;
   logic [2:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 load_q, load_d;
   logic [1:0]           shift_q, shift_d;
   logic                 busy_q, busy_d;
   logic [DATAWIDTH-1:0] data_q;

   sc_btn_sync_edge u_btn_left (
      .clk_i           (SC_RegSHIFTER_P1_CLOCK_50),
      .rst_i           (SC_RegSHIFTER_P1_RESET_InHigh),
      .btn_n_i         (btnLeft_InLow),
      .pressed_level_o (pressed_l_s),
      .press_pulse_o   (press_l_s)
   );

   sc_btn_sync_edge u_btn_right (
      .clk_i           (SC_RegSHIFTER_P1_CLOCK_50),
      .rst_i           (SC_RegSHIFTER_P1_RESET_InHigh),
      .btn_n_i         (btnRight_InLow),
      .pressed_level_o (pressed_r_s),
      .press_pulse_o   (press_r_s)
   );

   // Next-state and repeat-counter logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
         ST_IDLE: begin
            cnt_d = CNT_ZERO;
            // A press only counts while the other button is fully released;
            // simultaneous edges also land here because both levels are set.
            if (press_l_s && !pressed_r_s) begin
               state_d = ST_SHIFT_L;
            end else if (press_r_s && !pressed_l_s) begin
               state_d = ST_SHIFT_R;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT_L: begin
            state_d = ST_HOLD_L;
            cnt_d   = CNT_ZERO;
         end
         ST_SHIFT_R: begin
            state_d = ST_HOLD_R;
            cnt_d   = CNT_ZERO;
         end
         ST_HOLD_L: begin
            if (!pressed_l_s || pressed_r_s) begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_SHIFT_L;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HOLD_R: begin
            if (!pressed_r_s || pressed_l_s) begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_SHIFT_R;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Output decode: shift/busy follow the next state; the load pulse marks
   // the single cycle spent leaving INIT, so it fires on the first edge.
   always_comb begin
      shift_d = shift_code_of(state_d);
      busy_d  = is_hold_state(state_d);
      if (state_q == ST_INIT) begin
         load_d = 1'b0;
      end else begin
         load_d = 1'b1;
      end
   end

   // State, counter and registered outputs
   always_ff @(posedge SC_RegSHIFTER_P1_CLOCK_50 or posedge SC_RegSHIFTER_P1_RESET_InHigh) begin
      if (SC_RegSHIFTER_P1_RESET_InHigh) begin
         state_q <= ST_INIT;
         cnt_q   <= CNT_ZERO;
         load_q  <= 1'b1;
         shift_q <= SHIFT_HOLD;
         busy_q  <= 1'b0;
         data_q  <= INIT_VALUE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         load_q  <= load_d;
         shift_q <= shift_d;
         busy_q  <= busy_d;
         data_q  <= INIT_VALUE;
      end
   end

   assign load_OutLow        = load_q;
   assign shiftselection_Out = shift_q;
   assign busy_Out           = busy_q;
   assign data_OutBUS        = data_q;

endmodule

// File: tb/tb_sc_shiftcmd_controller.sv
// ----------------------------------------------------------------------------
// tb_sc_shiftcmd_controller
// Directed, table-driven bench for sc_shiftcmd_controller with REPEAT_TICKS=20,
// plus a behavioural model of the saturating one-hot shifter downstream.
// ----------------------------------------------------------------------------
module tb_sc_shiftcmd_controller;

   localparam int RT     = 20;
   localparam int PERIOD = RT + 1;
   localparam int FIRST  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_l = 1'b1;
   logic       btn_r = 1'b1;
   logic       load_n;
   logic [1:0] shsel;
   logic [7:0] data;
   logic       busy;
   logic [7:0] mreg;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int overlap_cnt = 0;
   int         pulse_cyc[$];
   logic [1:0] pulse_code[$];

   typedef struct {
      logic       left;
      logic       right;
      int         hold;
      int         exp_n;
      logic [1:0] exp_code;
      logic       exp_busy;
   } vec_t;

   vec_t vecs[6];

   sc_shiftcmd_controller #(
      .DATAWIDTH    (8),
      .INIT_VALUE   (8'b00000001),
      .REPEAT_TICKS (RT),
      .CNT_WIDTH    (5)
   ) dut (
      .SC_RegSHIFTER_P1_CLOCK_50     (clk),
      .SC_RegSHIFTER_P1_RESET_InHigh (rst),
      .btnLeft_InLow                 (btn_l),
      .btnRight_InLow                (btn_r),
      .load_OutLow                   (load_n),
      .shiftselection_Out            (shsel),
      .data_OutBUS                   (data),
      .busy_Out                      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Saturating one-hot shifter model (0x01 .. 0x08)
   always @(posedge clk or posedge rst) begin
      if (rst) mreg <= 8'h00;
      else if (!load_n) mreg <= data;
      else begin
         case (shsel)
            2'b01:   if (mreg != 8'h08) mreg <= mreg << 1;
            2'b10:   if (mreg != 8'h01) mreg <= mreg >> 1;
            default: ;
         endcase
      end
   end

   // Pulse log and load/shift exclusivity monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (shsel != 2'b00) begin
         pulse_cyc.push_back(cyc);
         pulse_code.push_back(shsel);
      end
      if (!load_n && shsel != 2'b00) overlap_cnt++;
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_pulses(input string name, input int base, input int p,
                               input int exp_n, input logic [1:0] exp_code);
      int n;
      n = pulse_cyc.size() - base;
      check({name, "_count"}, n, exp_n);
      if (n > 0 && exp_n > 0) begin
         check({name, "_first_ofs"}, pulse_cyc[base] - p, FIRST);
         for (int k = base; k < pulse_cyc.size(); k++) begin
            check({name, "_code"}, int'(pulse_code[k]), int'(exp_code));
            if (k > base) check({name, "_period"}, pulse_cyc[k] - pulse_cyc[k-1], PERIOD);
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int p, base;
      string nm;
      nm   = $sformatf("vec%0d", idx);
      base = pulse_cyc.size();
      p    = cyc;
      btn_l = ~v.left;
      btn_r = ~v.right;
      for (int i = 0; i < v.hold; i++) begin
         step(1);
         if (i == 7) check({nm, "_busy_hold"}, int'(busy), int'(v.exp_busy));
      end
      btn_l = 1'b1;
      btn_r = 1'b1;
      step(30);
      check_pulses(nm, base, p, v.exp_n, v.exp_code);
      check({nm, "_busy_idle"}, int'(busy), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(2);
   endtask

   initial begin
      int base, p;
      logic [7:0] exp_l[4];
      logic [7:0] exp_r[5];

      //           left  right hold n  code   busy
      vecs[0] = '{1'b1, 1'b0, 10, 1, 2'b01, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 70, 4, 2'b10, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 21, 1, 2'b01, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 22, 2, 2'b01, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 12, 1, 2'b10, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 10, 0, 2'b00, 1'b0};
      exp_l = '{8'h02, 8'h04, 8'h08, 8'h08};
      exp_r = '{8'h04, 8'h02, 8'h01, 8'h01, 8'h01};

      // Reset state and the post-reset load pulse
      step(2);
      check("rst_load", int'(load_n), 1);
      check("rst_shsel", int'(shsel), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_data", int'(data), 8'h01);
      rst = 1'b0;
      step(1);
      check("load_low", int'(load_n), 0);
      check("load_shsel", int'(shsel), 0);
      step(1);
      check("load_high", int'(load_n), 1);
      check("model_after_load", int'(mreg), 8'h01);
      base = pulse_cyc.size();
      step(10);
      check("idle_no_pulse", pulse_cyc.size() - base, 0);

      // Table-driven press/hold vectors
      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Both pressed together, right released while left held: no command
      // until left is released and pressed again
      base = pulse_cyc.size();
      btn_l = 1'b0; btn_r = 1'b0;
      step(10);
      btn_r = 1'b1;
      step(15);
      check("both_then_left_count", pulse_cyc.size() - base, 0);
      check("both_then_left_busy", int'(busy), 0);
      btn_l = 1'b1;
      step(5);
      base = pulse_cyc.size();
      p = cyc;
      btn_l = 1'b0;
      step(8);
      btn_l = 1'b1;
      step(10);
      check_pulses("repress_left", base, p, 1, 2'b01);

      // Reset in the middle of a left hold, button kept low
      btn_l = 1'b0;
      step(10);
      rst = 1'b1;
      #1;
      check("midrst_load", int'(load_n), 1);
      check("midrst_shsel", int'(shsel), 0);
      check("midrst_busy", int'(busy), 0);
      step(3);
      rst = 1'b0;
      base = pulse_cyc.size();
      step(1);
      check("midrst_load_low", int'(load_n), 0);
      step(1);
      check("midrst_load_high", int'(load_n), 1);
      step(20);
      check("midrst_held_no_pulse", pulse_cyc.size() - base, 0);
      btn_l = 1'b1;
      step(5);
      base = pulse_cyc.size();
      p = cyc;
      btn_l = 1'b0;
      step(8);
      btn_l = 1'b1;
      step(10);
      check_pulses("midrst_repress", base, p, 1, 2'b01);

      // Integration with the saturating shifter model
      do_reset();
      check("integ_reset_reg", int'(mreg), 8'h01);
      for (int i = 0; i < 4; i++) begin
         btn_l = 1'b0;
         step(3);
         btn_l = 1'b1;
         step(10);
         check($sformatf("integ_left%0d", i), int'(mreg), int'(exp_l[i]));
      end
      for (int i = 0; i < 5; i++) begin
         btn_r = 1'b0;
         step(3);
         btn_r = 1'b1;
         step(10);
         check($sformatf("integ_right%0d", i), int'(mreg), int'(exp_r[i]));
      end

      check("load_shift_exclusive", overlap_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
